mp_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer built around the team's single 16-bit ripple-carry adder (`LSB_RCA`, 4x `FA_4`).
- Latches two WORDS×16-bit operands on a start handshake. Streams them LSB word first through the one adder, one word per clock, with a registered carry between words.
- Returns the full-width result with carry/borrow and signed-overflow flags.
- Sits between the ALU-level control and the shared adder datapath.

---
 rtl/mp_add_seq_pkg.sv | 25 ++
 rtl/mp_add_seq_if.sv | 27 ++
 rtl/FA_4.sv | 24 ++
 rtl/LSB_RCA.sv | 16 +
 rtl/mp_add_seq.sv | 129 ++++++++++++
 tb/tb_mp_add_seq.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// the FSM state type, the adder slice width and the index-width helpers.
package mp_add_seq_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // Word index never narrower than one bit, even for single-word operands.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/result bundle between the ALU control (master) and the sequencer (slave).
interface mp_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    import mp_add_seq_pkg::*;

    logic                       start;
    logic                       op_sub;
    logic [SLICE_W*WORDS-1:0]   a_in;
    logic [SLICE_W*WORDS-1:0]   b_in;
    logic                       busy;
    logic                       done;
    logic [SLICE_W*WORDS-1:0]   result;
    logic                       carry_out;
    logic                       overflow;

    modport master (
        output start, op_sub, a_in, b_in,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op_sub, a_in, b_in,
        output busy, done, result, carry_out, overflow
    );

endinterface

// File: rtl/FA_4.sv
// 4-bit ripple-carry adder nibble built from generate/propagate terms.
module FA_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] p;
    logic [3:0] g;
    logic       c0, c1, c2, c3;

    assign p = a ^ b;
    assign g = a & b;

    assign c0 = g[0] | (p[0] & c_in);
    assign c1 = g[1] | (p[1] & c0);
    assign c2 = g[2] | (p[2] & c1);
    assign c3 = g[3] | (p[3] & c2);

    assign s     = p ^ {c2, c1, c0, c_in};
    assign c_out = c3;

endmodule

// File: rtl/LSB_RCA.sv
// Shared 16-bit ripple-carry adder: four chained FA_4 nibbles.
module LSB_RCA (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);
    logic c4, c8, c12;

    FA_4 u_fa0 (.a(a[3:0]),   .b(b[3:0]),   .c_in(c_in), .s(s[3:0]),   .c_out(c4));
    FA_4 u_fa1 (.a(a[7:4]),   .b(b[7:4]),   .c_in(c4),   .s(s[7:4]),   .c_out(c8));
    FA_4 u_fa2 (.a(a[11:8]),  .b(b[11:8]),  .c_in(c8),   .s(s[11:8]),  .c_out(c12));
    FA_4 u_fa3 (.a(a[15:12]), .b(b[15:12]), .c_in(c12),  .s(s[15:12]), .c_out(c_out));

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: streams WORDS 16-bit slices LSB first through
// the shared LSB_RCA adder, one slice per clock, with a registered inter-word carry.
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4,
    parameter int unsigned W     = SLICE_W
) (
    input logic          clk,
    input logic          rst_n,
    mp_add_seq_if.slave  bus
);
    localparam int unsigned   IW   = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d, idx_inc;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [W*WORDS-1:0] a_q, a_d;
    logic [W*WORDS-1:0] b_q, b_d;
    logic [W-1:0]       res_q [WORDS];
    logic [W-1:0]       res_d [WORDS];
    logic [W-1:0]       a_w [WORDS];
    logic [W-1:0]       b_w [WORDS];

    logic [W-1:0]       add_a, add_b, add_s;
    logic               add_ci, add_co;

    for (genvar g = 0; g < WORDS; g++) begin : g_words
        assign a_w[g]                = a_q[g*W +: W];
        assign b_w[g]                = b_q[g*W +: W];
        assign bus.result[g*W +: W]  = res_q[g];
    end

    // b_q already holds ~B for subtraction, so A-B becomes A + ~B + 1.
    assign add_a  = a_w[idx_q];
    assign add_b  = b_w[idx_q];
    assign add_ci = (idx_q == '0) ? sub_q : carry_q;

    LSB_RCA u_rca (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_ci),
        .s     (add_s),
        .c_out (add_co)
    );

    // Bitwise incrementer for the word index; no arithmetic operators here.
    always_comb begin : p_idx_inc
        logic c;
        c       = 1'b1;
        idx_inc = idx_q;
        for (int i = 0; i < IW; i++) begin
            idx_inc[i] = idx_q[i] ^ c;
            c          = c & idx_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a_in;
                    b_d     = bus.op_sub ? ~bus.b_in : bus.b_in;
                    sub_d   = bus.op_sub;
                    idx_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                res_d[idx_q] = add_s;
                carry_d      = add_co;
                if (idx_q == LAST) begin
                    state_d = StDone;
                    cout_d  = add_co;
                    ovf_d   = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
                end else begin
                    idx_d = idx_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: full-width arithmetic reference model checked
// every cycle, plus hand-computed literal results for each directed operation.
module tb_mp_add_seq;
    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = 16 * WORDS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mp_add_seq_if #(.WORDS(WORDS)) bus ();

    mp_add_seq #(.WORDS(WORDS), .W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Plain full-width arithmetic: {overflow, carry, result}.
    function automatic logic [N+1:0] calc(input logic sub, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
        logic [N:0] full;
        logic       v;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
            v    = (a[N-1] != b[N-1]) && (full[N-1] != a[N-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            v    = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        end
        return {v, full};
    endfunction

    // Reference model: accept when no op is outstanding, result appears WORDS edges later.
    int             m_cnt;
    logic           m_done;
    logic [N-1:0]   m_res, p_res;
    logic           m_c, m_v, p_c, p_v;
    logic           armed = 1'b0;

    always @(posedge clk) begin
        armed <= 1'b1;
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_c    <= 1'b0;
            m_v    <= 1'b0;
        end else if (m_cnt == 0 && bus.start) begin
            m_cnt                <= WORDS;
            m_done               <= 1'b0;
            {p_v, p_c, p_res}    <= calc(bus.op_sub, bus.a_in, bus.b_in);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_res  <= p_res;
                m_c    <= p_c;
                m_v    <= p_v;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk1("busy", bus.busy, m_cnt != 0);
            chk1("done", bus.done, m_done);
            if (m_cnt == 0) begin
                chk("result", bus.result, m_res);
                chk1("carry_out", bus.carry_out, m_c);
                chk1("overflow", bus.overflow, m_v);
            end
        end
    end

    task automatic drive(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.start  = 1'b1;
        bus.op_sub = sub;
        bus.a_in   = a;
        bus.b_in   = b;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_done: no done within %0d cycles", n);
        end
    endtask

    task automatic do_op(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat);
        drive(sub, a, b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
    endtask

    task automatic chk_out(input string name, input logic [N-1:0] r, input logic c,
                           input logic v);
        chk({name, " result"}, bus.result, r);
        chk1({name, " carry"}, bus.carry_out, c);
        chk1({name, " ovf"}, bus.overflow, v);
    endtask

    int lat;
    int pulses;

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset busy", bus.busy, 1'b0);
        chk1("reset done", bus.done, 1'b0);
        chk_out("reset", '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat);
        chk_int("add latency", lat, 4);
        chk_out("add wrap", 64'h0, 1'b1, 1'b0);

        do_op(1'b1, 64'h5, 64'h7, lat);
        chk_out("sub borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

        do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, lat);
        chk_out("add ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        do_op(1'b1, 64'h8000_0000_0000_0000, 64'h1, lat);
        chk_out("sub ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // start and operand changes during RUN must be ignored
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 64'h10, 64'h20);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        drive(1'b1, 64'hDEAD, 64'hBEEF);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = 64'h5555_5555;
        wait_done(lat);
        chk_int("ignore lat", lat, 1);
        chk_out("ignore", 64'h30, 1'b0, 1'b0);
        pulses = 1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        chk_int("ignore pulses", pulses, 1);

        // synchronous reset in the middle of RUN
        drive(1'b0, 64'h99, 64'h1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk1("abort busy", bus.busy, 1'b0);
        chk1("abort done", bus.done, 1'b0);
        chk_out("abort", '0, 1'b0, 1'b0);
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        chk_int("abort pulses", pulses, 0);
        do_op(1'b0, 64'h1234, 64'h1111, lat);
        chk_out("post reset", 64'h2345, 1'b0, 1'b0);

        // back-to-back: start held through the DONE cycle
        do_op(1'b0, 64'h3, 64'h4, lat);
        chk_out("b2b first", 64'h7, 1'b0, 1'b0);
        drive(1'b0, 64'h1_0000, 64'hFFFF);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk1("b2b done drop", bus.done, 1'b0);
        chk1("b2b busy", bus.busy, 1'b1);
        wait_done(lat);
        chk_int("b2b gap", lat + 1, 5);
        chk_out("b2b second", 64'h1_FFFF, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
